// File: rtl/counter_pkg.sv
// Shared definitions for the counter primitives.
//   MODE_WRAP / MODE_SATURATE : legal values of the SATURATE parameter.
//   clamp_to_modulus()        : limits a load value to the legal count range.
package counter_pkg;

    localparam int unsigned MODE_WRAP     = 0;
    localparam int unsigned MODE_SATURATE = 1;

    // Values outside 0..modulus-1 are pinned to the top of the range.
    function automatic int unsigned clamp_to_modulus(input int unsigned value,
                                                     input int unsigned modulus);
        return (value < modulus) ? value : (modulus - 1);
    endfunction

endpackage

// File: rtl/dff_r.sv
// Single-bit D flip-flop with asynchronous active-low reset.
//   clock   : rising-edge clock
//   reset_n : asynchronous reset, forces q=0
//   d       : data input
//   q       : registered output
//   q_      : complement of q
module dff_r (
    input  logic clock,
    input  logic reset_n,
    input  logic d,
    output logic q,
    output logic q_
);

    logic r_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_q <= 1'b0;
        end else begin
            r_q <= d;
        end
    end

    assign q  = r_q;
    assign q_ = ~r_q;

endmodule

// File: rtl/sync_updown_counter.sv
// Synchronous up/down modulo counter with load, clear, saturate and cascade outputs.
//   clock      : single rising-edge clock
//   reset_n    : asynchronous active-low reset (count=0, wrap=0)
//   clear      : synchronous clear, highest priority
//   load       : synchronous load of load_value (clamped to MODULUS-1)
//   enable     : count enable
//   up         : 1 = count up, 0 = count down
//   load_value : parallel load data
//   count      : registered count
//   count_n    : complement of count
//   terminal   : combinational carry/borrow for cascading
//   wrap       : registered one-cycle pulse after a wrap
module sync_updown_counter
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned MODULUS  = 16,
    parameter int unsigned SATURATE = MODE_WRAP
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             enable,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] count_n,
    output logic             terminal,
    output logic             wrap
);

    if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
        $error("sync_updown_counter: WIDTH must be 1..16");
    end
    if (MODULUS < 2 || MODULUS > (32'd1 << WIDTH)) begin : g_bad_modulus
        $error("sync_updown_counter: MODULUS must be 2..2**WIDTH");
    end
    if (SATURATE != MODE_WRAP && SATURATE != MODE_SATURATE) begin : g_bad_mode
        $error("sync_updown_counter: SATURATE must be 0 or 1");
    end

    localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(MODULUS - 1);
    localparam bit               SAT_MODE  = (SATURATE == MODE_SATURATE);

    logic [WIDTH-1:0] w_count;
    logic [WIDTH-1:0] w_count_n;
    logic [WIDTH-1:0] w_next_count;
    logic             w_next_wrap;
    logic             w_wrap_q;
    logic             w_wrap_n_unused;
    logic             w_at_top;
    logic             w_at_bottom;
    logic [WIDTH-1:0] w_load_clamped;

    assign w_at_top       = (w_count == MAX_COUNT);
    assign w_at_bottom    = (w_count == '0);
    assign w_load_clamped = WIDTH'(clamp_to_modulus(32'(load_value), MODULUS));

    // Explicit bound compares make non-power-of-two moduli wrap correctly.
    always_comb begin
        w_next_count = w_count;
        w_next_wrap  = 1'b0;
        if (clear) begin
            w_next_count = '0;
        end else if (load) begin
            w_next_count = w_load_clamped;
        end else if (enable) begin
            if (up) begin
                if (!w_at_top) begin
                    w_next_count = w_count + WIDTH'(1);
                end else if (!SAT_MODE) begin
                    w_next_count = '0;
                    w_next_wrap  = 1'b1;
                end
            end else begin
                if (!w_at_bottom) begin
                    w_next_count = w_count - WIDTH'(1);
                end else if (!SAT_MODE) begin
                    w_next_count = MAX_COUNT;
                    w_next_wrap  = 1'b1;
                end
            end
        end
    end

    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_count_bit
        dff_r u_dff_count (
            .clock   (clock),
            .reset_n (reset_n),
            .d       (w_next_count[i]),
            .q       (w_count[i]),
            .q_      (w_count_n[i])
        );
    end

    dff_r u_dff_wrap (
        .clock   (clock),
        .reset_n (reset_n),
        .d       (w_next_wrap),
        .q       (w_wrap_q),
        .q_      (w_wrap_n_unused)
    );

    assign count    = w_count;
    assign count_n  = w_count_n;
    assign wrap     = w_wrap_q;
    // Independent of clear/load/SATURATE so a cascade sees the raw carry/borrow.
    assign terminal = enable & (up ? w_at_top : w_at_bottom);

endmodule

// File: tb/tb_sync_updown_counter.sv
// Self-checking bench for sync_updown_counter: directed steps plus random stimulus,
// compared against a modulo-arithmetic reference model.
module tb_sync_updown_counter;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset_n;

    // Instance A: WIDTH=4, MODULUS=10, wrap mode
    logic       a_clear, a_enable, a_up, a_load;
    logic [3:0] a_lv, a_count, a_count_n;
    logic       a_term, a_wrap;

    // Instance B: WIDTH=4, MODULUS=16, saturate mode
    logic       b_clear, b_enable, b_up, b_load;
    logic [3:0] b_lv, b_count, b_count_n;
    logic       b_term, b_wrap;

    // Cascade: two decade stages
    logic       c_en;
    logic [3:0] c0_count, c0_count_n, c1_count, c1_count_n;
    logic       c0_term, c0_wrap, c1_term, c1_wrap;

    sync_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_dut_a (
        .clock(clock), .reset_n(reset_n), .clear(a_clear), .enable(a_enable), .up(a_up),
        .load(a_load), .load_value(a_lv), .count(a_count), .count_n(a_count_n),
        .terminal(a_term), .wrap(a_wrap)
    );

    sync_updown_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(1)) u_dut_b (
        .clock(clock), .reset_n(reset_n), .clear(b_clear), .enable(b_enable), .up(b_up),
        .load(b_load), .load_value(b_lv), .count(b_count), .count_n(b_count_n),
        .terminal(b_term), .wrap(b_wrap)
    );

    sync_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_dut_c0 (
        .clock(clock), .reset_n(reset_n), .clear(1'b0), .enable(c_en), .up(1'b1),
        .load(1'b0), .load_value(4'd0), .count(c0_count), .count_n(c0_count_n),
        .terminal(c0_term), .wrap(c0_wrap)
    );

    sync_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_dut_c1 (
        .clock(clock), .reset_n(reset_n), .clear(1'b0), .enable(c0_term), .up(1'b1),
        .load(1'b0), .load_value(4'd0), .count(c1_count), .count_n(c1_count_n),
        .terminal(c1_term), .wrap(c1_wrap)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int ma, mb, mv;
    bit ma_wrap, mb_wrap, mc0_wrap, mc1_wrap;

    function automatic int model_next(input int cnt, input int modulus, input bit sat,
                                      input bit clr, input bit ld, input int lv,
                                      input bit en, input bit upd);
        if (clr) return 0;
        if (ld) return (lv < modulus) ? lv : modulus - 1;
        if (!en) return cnt;
        if (upd) return sat ? ((cnt == modulus - 1) ? cnt : cnt + 1) : (cnt + 1) % modulus;
        return sat ? ((cnt == 0) ? 0 : cnt - 1) : (cnt + modulus - 1) % modulus;
    endfunction

    function automatic bit model_wrap(input int cnt, input int modulus, input bit sat,
                                      input bit clr, input bit ld, input bit en,
                                      input bit upd);
        return !clr && !ld && en && !sat && (upd ? (cnt == modulus - 1) : (cnt == 0));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("a_count", 32'(a_count), 32'(ma));
        check("a_count_n", 32'(a_count_n), 32'(15 - ma));
        check("a_wrap", 32'(a_wrap), 32'(ma_wrap));
        check("a_term", 32'(a_term), 32'(a_enable && (a_up ? ma == 9 : ma == 0)));
        check("b_count", 32'(b_count), 32'(mb));
        check("b_count_n", 32'(b_count_n), 32'(15 - mb));
        check("b_wrap", 32'(b_wrap), 32'(mb_wrap));
        check("b_term", 32'(b_term), 32'(b_enable && (b_up ? mb == 15 : mb == 0)));
        check("c0_count", 32'(c0_count), 32'(mv % 10));
        check("c1_count", 32'(c1_count), 32'(mv / 10));
        check("c0_wrap", 32'(c0_wrap), 32'(mc0_wrap));
        check("c1_wrap", 32'(c1_wrap), 32'(mc1_wrap));
        check("c0_term", 32'(c0_term), 32'(c_en && (mv % 10 == 9)));
        check("c1_term", 32'(c1_term), 32'(c_en && mv == 99));
    endtask

    // One clock edge: advance the model from the inputs seen at the edge, then compare.
    task automatic tick();
        int  na, nb;
        bit  wa, wb;
        @(posedge clock);
        na = model_next(ma, 10, 1'b0, a_clear, a_load, int'(a_lv), a_enable, a_up);
        wa = model_wrap(ma, 10, 1'b0, a_clear, a_load, a_enable, a_up);
        nb = model_next(mb, 16, 1'b1, b_clear, b_load, int'(b_lv), b_enable, b_up);
        wb = model_wrap(mb, 16, 1'b1, b_clear, b_load, b_enable, b_up);
        ma = na; ma_wrap = wa;
        mb = nb; mb_wrap = wb;
        mc0_wrap = c_en && (mv % 10 == 9);
        mc1_wrap = c_en && (mv == 99);
        if (c_en) mv = (mv + 1) % 100;
        #1;
        check_all();
    endtask

    int c1_pulses;

    initial begin
        reset_n = 1'b0;
        {a_clear, a_enable, a_up, a_load} = '0; a_lv = '0;
        {b_clear, b_enable, b_up, b_load} = '0; b_lv = '0;
        c_en = 1'b0;
        ma = 0; mb = 0; mv = 0;
        ma_wrap = 0; mb_wrap = 0; mc0_wrap = 0; mc1_wrap = 0;

        // Reset state
        #2;
        check("rst_a_count", 32'(a_count), 32'd0);
        check("rst_a_count_n", 32'(a_count_n), 32'hF);
        check("rst_a_wrap", 32'(a_wrap), 32'd0);
        #1 reset_n = 1'b1;

        // Count up through the modulus-10 wrap
        a_enable = 1'b1; a_up = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            tick();
            check("up_seq", 32'(a_count), 32'(e % 10));
            check("up_wrap", 32'(a_wrap), 32'(e == 10));
        end

        // Load 1 then count down across zero
        #1 a_lv = 4'd1; a_load = 1'b1;
        tick();
        check("load1", 32'(a_count), 32'd1);
        a_load = 1'b0; a_up = 1'b0;
        tick();
        check("down_0", 32'(a_count), 32'd0);
        check("down_term0", 32'(a_term), 32'd1);
        tick();
        check("down_9", 32'(a_count), 32'd9);
        check("down_wrap", 32'(a_wrap), 32'd1);

        // Saturate instance: hold at 15, never wrap
        a_enable = 1'b0;
        b_lv = 4'd14; b_load = 1'b1;
        tick();
        b_load = 1'b0; b_enable = 1'b1; b_up = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("sat_top", 32'(b_count), 32'd15);
            check("sat_nowrap", 32'(b_wrap), 32'd0);
        end
        b_up = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("sat_down", 32'(b_count), 32'(15 - i));
        end
        b_enable = 1'b0;

        // Priority and clamp
        a_clear = 1'b1; a_load = 1'b1; a_enable = 1'b1; a_lv = 4'd5;
        tick();
        check("clr_prio", 32'(a_count), 32'd0);
        a_clear = 1'b0; a_lv = 4'd12;
        tick();
        check("load_clamp", 32'(a_count), 32'd9);
        a_load = 1'b0; a_enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold", 32'(a_count), 32'd9);
        end

        // Asynchronous reset while the wrap pulse is high
        a_lv = 4'd0; a_load = 1'b1;
        tick();
        a_load = 1'b0; a_enable = 1'b1; a_up = 1'b0;
        tick();
        check("pre_rst_wrap", 32'(a_wrap), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("async_count", 32'(a_count), 32'd0);
        check("async_wrap", 32'(a_wrap), 32'd0);
        check("async_count_n", 32'(a_count_n), 32'hF);
        ma = 0; ma_wrap = 0; mb = 0; mb_wrap = 0; mv = 0; mc0_wrap = 0; mc1_wrap = 0;
        a_enable = 1'b0;
        #2 reset_n = 1'b1;
        tick();

        // Random stimulus
        for (int i = 0; i < 300; i++) begin
            a_clear = ($urandom % 16) == 0; a_load = ($urandom % 8) == 0;
            a_enable = ($urandom % 4) != 0; a_up = 1'($urandom); a_lv = 4'($urandom);
            b_clear = ($urandom % 16) == 0; b_load = ($urandom % 8) == 0;
            b_enable = ($urandom % 4) != 0; b_up = 1'($urandom); b_lv = 4'($urandom);
            tick();
        end
        {a_clear, a_enable, a_load, b_clear, b_enable, b_load} = '0;

        // Two-stage decade cascade, 100 edges back to 00
        c1_pulses = 0;
        c_en = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (c1_wrap) c1_pulses++;
        end
        check("casc_c0_end", 32'(c0_count), 32'd0);
        check("casc_c1_end", 32'(c1_count), 32'd0);
        check("casc_c1_pulses", 32'(c1_pulses), 32'd1);
        c_en = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
